char_bank_arbiter: RTL

//  Owns the memory-mapped character-state bank: x, y and vel for each of NUM_CHARS characters.

---
 rtl/char_bank_pkg.sv | 20 ++
 rtl/char_snapshot.sv | 47 ++++
 rtl/char_bank_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/char_bank_pkg.sv
// Shared encodings for the character-state bank: field selects, engine FSM states, default MMIO base.
package char_bank_pkg;

  typedef enum logic [1:0] {
    FLD_X    = 2'd0,
    FLD_Y    = 2'd1,
    FLD_VEL  = 2'd2,
    FLD_RSVD = 2'd3
  } fld_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_DONE = 2'd2
  } eng_state_e;

  localparam int         DEFAULT_BASE_ADDR = 4200;
  localparam logic [7:0] STARVE_SAT        = 8'd255;

endpackage

// File: rtl/char_snapshot.sv
// Shadow copy of every character's x/y, reloaded on a vsync rising edge so the renderer sees a
// frame-consistent position set. Only instantiated when CHAR_SNAPSHOT_EN is defined.
module char_snapshot
  import char_bank_pkg::*;
#(
  parameter int NUM_CHARS = 4,
  parameter int INIT_X    = 240,
  parameter int INIT_Y    = 240
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic [NUM_CHARS-1:0][31:0] live_x,
  input  logic [NUM_CHARS-1:0][31:0] live_y,
  output logic [NUM_CHARS-1:0][31:0] shadow_x,
  output logic [NUM_CHARS-1:0][31:0] shadow_y
);

  logic                       vsync_q;
  logic                       vsync_rise;
  logic [NUM_CHARS-1:0][31:0] shadow_x_q, shadow_y_q;

  assign vsync_rise = vsync && !vsync_q;

  // NOTE: state is updated with <= so every flop samples pre-edge values; that is exactly what
  // keeps a same-edge bank write out of the snapshot. The shadow is a handful of flops, not a
  // RAM, so it is reset to the same init values as the live bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      vsync_q <= 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) begin
        shadow_x_q[i] <= 32'(INIT_X);
        shadow_y_q[i] <= 32'(INIT_Y);
      end
    end else begin
      vsync_q <= vsync;
      if (vsync_rise) begin
        shadow_x_q <= live_x;
        shadow_y_q <= live_y;
      end
    end
  end

  assign shadow_x = shadow_x_q;
  assign shadow_y = shadow_y_q;

endmodule

// File: rtl/char_bank_arbiter.sv
// Character-state bank (x/y/vel per character) shared by a never-stalling processor MMIO port and
// a req/gnt game-engine port, with renderer position reads. CHAR_SNAPSHOT_EN: vsync-latched vga_x/y.
module char_bank_arbiter
  import char_bank_pkg::*;
#(
  parameter int  NUM_CHARS    = 4,
  parameter int  BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int  STARVE_LIMIT = 64,
  parameter int  INIT_X       = 240,
  parameter int  INIT_Y       = 240,
  localparam int IDX_W        = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [16:0]      proc_addr,
  input  logic [31:0]      proc_wdata,
  input  logic             proc_wren,
  output logic             proc_hit,
  output logic [31:0]      proc_rdata,
  input  logic             eng_req,
  input  logic             eng_we,
  input  logic [IDX_W-1:0] eng_idx,
  input  logic [1:0]       eng_field,
  input  logic [31:0]      eng_wdata,
  output logic             eng_gnt,
  output logic             eng_rvalid,
  output logic [31:0]      eng_rdata,
  output logic             eng_starved,
  input  logic             vga_vsync,
  input  logic [IDX_W-1:0] vga_idx,
  output logic [31:0]      vga_x,
  output logic [31:0]      vga_y
);

  localparam logic [16:0] ADDR_LO = 17'(BASE_ADDR);
  localparam logic [16:0] ADDR_HI = 17'(BASE_ADDR + 4 * NUM_CHARS);

  logic [NUM_CHARS-1:0][31:0] x_q, y_q, vel_q, x_d, y_d, vel_d;
  logic [NUM_CHARS-1:0][31:0] view_x, view_y;
  logic [16:0]                proc_off;
  logic [IDX_W-1:0]           proc_idx, wr_idx;
  fld_e                       proc_fld, wr_fld;
  logic                       wr_en;
  logic [31:0]                wr_data;
  eng_state_e                 state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       starved_q;
  logic                       unused_bits;

  function automatic logic [31:0] bank_rd(input logic [IDX_W-1:0] idx, input fld_e fld);
    logic [31:0] val;
    val = '0;
    if (int'(idx) < NUM_CHARS) begin
      case (fld)
        FLD_X:   val = x_q[idx];
        FLD_Y:   val = y_q[idx];
        FLD_VEL: val = vel_q[idx];
        default: val = '0;
      endcase
    end
    return val;
  endfunction

  assign proc_hit = (proc_addr >= ADDR_LO) && (proc_addr < ADDR_HI);
  assign proc_off = proc_addr - ADDR_LO;
  assign proc_idx = proc_off[IDX_W+1:2];
  assign proc_fld = fld_e'(proc_off[1:0]);

  // Processor writes win outright; the engine can only be granted when the processor is absent.
  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_fld  = FLD_RSVD;
    wr_data = '0;
    if (proc_hit && proc_wren) begin
      wr_en   = 1'b1;
      wr_idx  = proc_idx;
      wr_fld  = proc_fld;
      wr_data = proc_wdata;
    end else if (eng_gnt && eng_we && (int'(eng_idx) < NUM_CHARS)) begin
      wr_en   = 1'b1;
      wr_idx  = eng_idx;
      wr_fld  = fld_e'(eng_field);
      wr_data = eng_wdata;
    end
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    vel_d = vel_q;
    if (wr_en) begin
      case (wr_fld)
        FLD_X:   x_d[wr_idx]   = wr_data;
        FLD_Y:   y_d[wr_idx]   = wr_data;
        FLD_VEL: vel_d[wr_idx] = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        x_q[i]   <= 32'(INIT_X);
        y_q[i]   <= 32'(INIT_Y);
        vel_q[i] <= '0;
      end
      proc_rdata <= '0;
      eng_rdata  <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      vel_q <= vel_d;
      if (proc_hit && !proc_wren) proc_rdata <= bank_rd(proc_idx, proc_fld);
      if (eng_gnt && !eng_we)     eng_rdata  <= bank_rd(eng_idx, fld_e'(eng_field));
    end
  end

  // Engine FSM: state register, next-state logic, outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starved_q <= starved_q | (cnt_d == 8'(STARVE_LIMIT));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (eng_req) state_d = ST_ARB;
      ST_ARB: begin
        if (!proc_hit)               state_d = ST_DONE;
        else if (cnt_q != STARVE_SAT) cnt_d   = cnt_q + 8'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with reset keeps an access in flight from committing on the reset edge.
  always_comb begin
    eng_gnt    = (state_q == ST_ARB) && !proc_hit && !reset;
    eng_rvalid = (state_q == ST_DONE);
  end

  assign eng_starved = starved_q;

`ifdef CHAR_SNAPSHOT_EN
  char_snapshot #(
    .NUM_CHARS (NUM_CHARS),
    .INIT_X    (INIT_X),
    .INIT_Y    (INIT_Y)
  ) u_snapshot (
    .clock    (clock),
    .reset    (reset),
    .vsync    (vga_vsync),
    .live_x   (x_q),
    .live_y   (y_q),
    .shadow_x (view_x),
    .shadow_y (view_y)
  );
  assign unused_bits = ^proc_off[16:IDX_W+2];
`else
  assign view_x      = x_q;
  assign view_y      = y_q;
  assign unused_bits = ^{proc_off[16:IDX_W+2], vga_vsync};
`endif

  always_comb begin
    vga_x = '0;
    vga_y = '0;
    if (int'(vga_idx) < NUM_CHARS) begin
      vga_x = view_x[vga_idx];
      vga_y = view_y[vga_idx];
    end
  end

endmodule
